qerv_pc_seq: RTL and testbench

QERV_PC_SEQ -- requirements
Module: qerv_pc_seq

---
 rtl/qerv_pkg.sv | 7 +
 rtl/qerv_cnt.sv | 37 +++
 rtl/qerv_pc_seq.sv | 85 ++++++++
 tb/tb_qerv_pc_seq.sv | 130 +++++++++++++
 4 files changed

// File: rtl/qerv_pkg.sv
// qerv_pkg: shared FSM state encoding and counter sizing for the PC sequencer.
package qerv_pkg;
  typedef enum logic [1:0] {FETCH = 2'd0, DECODE = 2'd1, INIT = 2'd2, RUN = 2'd3} state_e;
  function automatic int cnt_bits(int w);
    return w == 4 ? 3 : 5;
  endfunction
endpackage

// File: rtl/qerv_cnt.sv
// qerv_cnt: bit-position counter with strobe decode; one step covers W bits of a 32-bit word.
module qerv_cnt import qerv_pkg::*; #(
  parameter int W = 1
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_run,
  output logic o_cnt0,
  output logic o_cnt1,
  output logic o_cnt2,
  output logic o_cnt03,
  output logic o_cnt12to31,
  output logic o_cnt_done
);
  localparam int CW = cnt_bits(W);
  localparam int N = 32 / W;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] C1 = CW'(W == 4 ? 0 : 1);
  localparam logic [CW-1:0] C2 = CW'(W == 4 ? 0 : 2);
  localparam logic [CW-1:0] C3 = CW'(W == 4 ? 0 : 3);
  localparam logic [CW-1:0] C12 = CW'(W == 4 ? 3 : 12);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = i_start ? '0 : i_run ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (i_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  always_comb begin
    o_cnt0 = i_run && cnt_q == '0;
    o_cnt1 = i_run && cnt_q == C1;
    o_cnt2 = i_run && cnt_q == C2;
    o_cnt03 = i_run && cnt_q <= C3;
    o_cnt12to31 = i_run && cnt_q >= C12;
    o_cnt_done = i_run && cnt_q == LAST;
  end
endmodule

// File: rtl/qerv_pc_seq.sv
// qerv_pc_seq: fetch/decode/init/run sequencer driving the bit-serial PC datapath.
// Trap logic and misalign check compiled in only with QERV_PC_SEQ_TRAP_EN.
module qerv_pc_seq import qerv_pkg::*; #(
  parameter int W = 1,
  parameter int TRAP_VEC_CHK = 1
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_ibus_ack,
  input  logic i_two_stage,
  input  logic i_cond_jump,
  input  logic i_jal_or_jalr,
  input  logic i_take,
  input  logic i_misalign,
  input  logic i_trap_req,
  output logic o_ibus_cyc,
  output logic o_pc_en,
  output logic o_jump,
  output logic o_trap,
  output logic o_init,
  output logic o_cnt0,
  output logic o_cnt1,
  output logic o_cnt2,
  output logic o_cnt03,
  output logic o_cnt12to31,
  output logic o_cnt_done
);
  state_e state_q, state_d;
  logic jal_q, br_q, take_q, trap_w, act, init_last;
  assign act = !i_rst && (state_q == INIT || state_q == RUN);
  assign init_last = state_q == INIT && o_cnt_done;
  qerv_cnt #(.W(W)) u_cnt (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_start     (state_q == DECODE),
    .i_run       (act),
    .o_cnt0      (o_cnt0),
    .o_cnt1      (o_cnt1),
    .o_cnt2      (o_cnt2),
    .o_cnt03     (o_cnt03),
    .o_cnt12to31 (o_cnt12to31),
    .o_cnt_done  (o_cnt_done)
  );
  always_ff @(posedge clk) begin
    if (i_rst) state_q <= FETCH;
    else state_q <= state_d;
  end
  always_comb
    state_d = state_q == FETCH ? (i_ibus_ack ? DECODE : FETCH) :
              state_q == DECODE ? (i_two_stage ? INIT : RUN) :
              !o_cnt_done ? state_q : state_q == INIT ? RUN : FETCH;
  always_ff @(posedge clk) begin
    if (i_rst) begin
      jal_q <= 1'b0;
      br_q <= 1'b0;
      take_q <= 1'b0;
    end else if (state_q == DECODE) begin
      jal_q <= i_jal_or_jalr;
      br_q <= i_cond_jump;
      take_q <= 1'b0;
    end else if (init_last) begin
      take_q <= i_take;
    end
  end
`ifdef QERV_PC_SEQ_TRAP_EN
  logic trap_q;
  always_ff @(posedge clk) begin
    if (i_rst) trap_q <= 1'b0;
    else if (state_q == DECODE) trap_q <= i_trap_req;
    else if (init_last && TRAP_VEC_CHK != 0 && i_misalign && (jal_q || (br_q && i_take))) trap_q <= 1'b1;
  end
  assign trap_w = trap_q;
`else
  logic unused_trap;
  assign unused_trap = ^{i_trap_req, i_misalign, TRAP_VEC_CHK != 0};
  assign trap_w = 1'b0;
`endif
  always_comb begin
    o_ibus_cyc = !i_rst && state_q == FETCH;
    o_init = !i_rst && state_q == INIT;
    o_pc_en = !i_rst && state_q == RUN;
    o_trap = o_pc_en && trap_w;
    o_jump = o_pc_en && !trap_w && (jal_q || (br_q && take_q));
  end
endmodule

// File: tb/tb_qerv_pc_seq.sv
// tb_qerv_pc_seq: W=1 and W=4 sequencers on shared stimulus, each checked against a cycle-position model.
module tb_qerv_pc_seq;
  logic clk = 0, rst, ack, two, cond, jal_in, take, mis, trq;
  logic [10:0] o1, o4;
  int total = 0, bad = 0;
  int wv[2] = '{1, 4};
  bit busy[2], ts[2], jal[2], br[2], tk[2], tr[2];
  int k[2];
  always #5 clk = ~clk;

  qerv_pc_seq #(.W(1)) u_w1 (
    .clk(clk), .i_rst(rst), .i_ibus_ack(ack), .i_two_stage(two), .i_cond_jump(cond),
    .i_jal_or_jalr(jal_in), .i_take(take), .i_misalign(mis), .i_trap_req(trq),
    .o_ibus_cyc(o1[10]), .o_pc_en(o1[9]), .o_jump(o1[8]), .o_trap(o1[7]), .o_init(o1[6]),
    .o_cnt0(o1[5]), .o_cnt1(o1[4]), .o_cnt2(o1[3]), .o_cnt03(o1[2]), .o_cnt12to31(o1[1]),
    .o_cnt_done(o1[0]));
  qerv_pc_seq #(.W(4)) u_w4 (
    .clk(clk), .i_rst(rst), .i_ibus_ack(ack), .i_two_stage(two), .i_cond_jump(cond),
    .i_jal_or_jalr(jal_in), .i_take(take), .i_misalign(mis), .i_trap_req(trq),
    .o_ibus_cyc(o4[10]), .o_pc_en(o4[9]), .o_jump(o4[8]), .o_trap(o4[7]), .o_init(o4[6]),
    .o_cnt0(o4[5]), .o_cnt1(o4[4]), .o_cnt2(o4[3]), .o_cnt03(o4[2]), .o_cnt12to31(o4[1]),
    .o_cnt_done(o4[0]));

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
    end
  endtask

  // k counts cycles since the ack edge: k=1 decode, then INIT/RUN positions follow.
  function automatic logic [10:0] expv(int i);
    int n, pos, lo, hi;
    bit init, run;
    n = 32 / wv[i];
    if (rst) return '0;
    if (!busy[i]) return 11'b100_0000_0000;
    init = ts[i] && k[i] >= 2 && k[i] <= n + 1;
    run = ts[i] ? k[i] >= n + 2 : k[i] >= 2;
    if (!(init || run)) return '0;
    pos = (ts[i] && run) ? k[i] - n - 2 : k[i] - 2;
    lo = pos * wv[i];
    hi = lo + wv[i] - 1;
    return {1'b0, run, run && !tr[i] && (jal[i] || (br[i] && tk[i])), run && tr[i], init,
            lo == 0, lo <= 1 && 1 <= hi, lo <= 2 && 2 <= hi, lo <= 3, lo >= 12, pos == n - 1};
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int n;
      n = 32 / wv[i];
      if (rst) begin
        busy[i] = 0; ts[i] = 0; jal[i] = 0; br[i] = 0; tk[i] = 0; tr[i] = 0;
      end else if (!busy[i]) begin
        if (ack) begin busy[i] = 1; k[i] = 1; end
      end else begin
        if (k[i] == 1) begin
          ts[i] = two; jal[i] = jal_in; br[i] = cond; tk[i] = 0;
`ifdef QERV_PC_SEQ_TRAP_EN
          tr[i] = trq;
`else
          tr[i] = 0;
`endif
        end
        if (ts[i] && k[i] == n + 1) begin
          tk[i] = take;
`ifdef QERV_PC_SEQ_TRAP_EN
          if (mis && (jal[i] || (br[i] && take))) tr[i] = 1;
`endif
        end
        k[i]++;
        if (k[i] == (ts[i] ? 2 + 2 * n : 2 + n)) busy[i] = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("w1", o1, expv(0));
    check("w4", o4, expv(1));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic op(input bit t, c, j, tkv, m, tq, input int cycles);
    two = t; cond = c; jal_in = j; take = tkv; mis = m; trq = tq;
    ack = 1;
    tick();
    ack = 0;
    repeat (cycles) tick();
  endtask

  initial begin
    rst = 1; ack = 0; two = 0; cond = 0; jal_in = 0; take = 0; mis = 0; trq = 0;
    #1;
    repeat (2) tick();
    rst = 0;
    repeat (5) tick();
    op(0, 0, 0, 0, 0, 0, 40);
    op(1, 1, 0, 1, 0, 0, 70);
    op(1, 1, 0, 0, 0, 0, 70);
    op(1, 0, 1, 0, 1, 0, 70);
    op(1, 1, 0, 1, 1, 0, 70);
    op(0, 0, 1, 0, 0, 1, 40);
    op(0, 0, 1, 1, 1, 0, 11);
    ack = 1;
    repeat (3) tick();
    rst = 1;
    tick();
    rst = 0;
    ack = 0;
    repeat (3) tick();
    op(0, 1, 0, 1, 0, 0, 40);
    for (int c = 0; c < 4000; c++) begin
      rst = $urandom_range(0, 199) == 0;
      ack = $urandom_range(0, 3) == 0;
      two = $urandom_range(0, 1) != 0;
      cond = $urandom_range(0, 1) != 0;
      jal_in = $urandom_range(0, 1) != 0;
      take = $urandom_range(0, 1) != 0;
      mis = $urandom_range(0, 2) == 0;
      trq = $urandom_range(0, 5) == 0;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
